// File: rtl/sdram_read_pkg.sv
// Shared definitions for the SDRAM read arbiter.
//   state_t    : transfer FSM state encoding
//   DEF_*      : default parameter values for the arbiter
//   max_burst  : largest Avalon burst expressible with a given burstcount width
package sdram_read_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_NUM_CH  = 3;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_ADDR_W  = 29;
  localparam int DEF_BURST_W = 8;
  localparam int DEF_LEN_W   = 16;

  // Avalon burstcount is 1-based with the top bit reserved for the maximum,
  // so a BURST_W-bit field carries bursts up to 2^(BURST_W-1) words.
  function automatic int max_burst(input int burst_w);
    return 1 << (burst_w - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant generator.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_req        : per-channel request vector
//   i_advance    : accept the current grant; priority moves past the winner
//   o_grant      : one-hot grant (all zero when nothing requests)
module rr_arbiter #(
  parameter int NUM_CH = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_advance,
  output logic [NUM_CH-1:0] o_grant
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // r_ptr is the channel holding highest priority on the next grant.
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_next_ptr;

  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             found;
    o_grant    = '0;
    w_next_ptr = r_ptr;
    found      = 1'b0;
    idx        = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = PTR_W'((int'(r_ptr) + off) % NUM_CH);
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        w_next_ptr   = PTR_W'((int'(idx) + 1) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_advance && (|i_req)) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/sdram_read_arbiter.sv
// Multi-channel read arbiter in front of an Avalon-MM burst read port.
// Channels request a (start address, length) transfer; the winner is split
// into bursts of at most MAX_BURST words, one burst outstanding at a time,
// and its data is returned on a shared bus qualified per channel.
//   clk, reset_n        : clock, asynchronous active-low reset
//   ch_req/addr/len     : per-channel transfer request, held until ch_ack
//   ch_ack              : one-cycle accept pulse
//   ch_rdata/ch_rvalid  : shared read data, one-hot beat qualifier
//   ch_done             : one-cycle completion pulse
//   busy                : transfer FSM not idle
//   avm_*               : Avalon-MM burst read master
module sdram_read_arbiter
  import sdram_read_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     busy,
  output logic [ADDR_W-1:0]        avm_address,
  output logic [BURST_W-1:0]       avm_burstcount,
  output logic                     avm_read,
  input  logic                     avm_waitrequest,
  input  logic [DATA_W-1:0]        avm_readdata,
  input  logic                     avm_readdatavalid
);

  localparam int MAX_BURST = max_burst(BURST_W);

  state_t              r_state, w_state_nxt;
  logic [NUM_CH-1:0]   r_gnt;      // one-hot owner of the current transfer
  logic [ADDR_W-1:0]   r_addr;     // address of the current/next burst
  logic [LEN_W-1:0]    r_remain;   // words still to be received
  logic [BURST_W-1:0]  r_bcnt;     // size of the current/next burst
  logic [BURST_W-1:0]  r_beats;    // beats left in the burst in flight
  logic [NUM_CH-1:0]   r_ack;
  logic [NUM_CH-1:0]   r_rvalid;
  logic [NUM_CH-1:0]   r_done;
  logic [DATA_W-1:0]   r_rdata;

  logic [NUM_CH-1:0]   w_grant;
  logic                w_advance;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [LEN_W-1:0]    w_sel_len;
  logic                w_last_beat;

  function automatic logic [BURST_W-1:0] burst_of(input logic [LEN_W-1:0] rem);
    if (32'(rem) >= 32'(MAX_BURST)) burst_of = BURST_W'(MAX_BURST);
    else                             burst_of = BURST_W'(rem);
  endfunction

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (ch_req),
    .i_advance (w_advance),
    .o_grant   (w_grant)
  );

  // Address/length of the channel the arbiter would grant this cycle.
  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
        w_sel_len  = ch_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign w_last_beat = avm_readdatavalid && (r_beats == BURST_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|ch_req) begin
          w_advance   = 1'b1;
          // A zero-length transfer skips the bus entirely.
          w_state_nxt = (w_sel_len == '0) ? ST_DONE : ST_CMD;
        end
      end
      ST_CMD: begin
        if (!avm_waitrequest) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_last_beat) begin
          w_state_nxt = (r_remain == LEN_W'(1)) ? ST_DONE : ST_CMD;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt    <= '0;
      r_addr   <= '0;
      r_remain <= '0;
      r_bcnt   <= '0;
      r_beats  <= '0;
      r_ack    <= '0;
      r_rvalid <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
    end else begin
      r_ack    <= '0;
      r_rvalid <= '0;
      r_done   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|ch_req) begin
            r_ack    <= w_grant;
            r_gnt    <= w_grant;
            r_addr   <= w_sel_addr;
            r_remain <= w_sel_len;
            r_bcnt   <= burst_of(w_sel_len);
          end
        end
        ST_CMD: begin
          if (!avm_waitrequest) r_beats <= r_bcnt;
        end
        ST_DATA: begin
          if (avm_readdatavalid) begin
            r_rdata  <= avm_readdata;
            r_rvalid <= r_gnt;
            r_beats  <= r_beats - BURST_W'(1);
            r_remain <= r_remain - LEN_W'(1);
            // Set up the follow-on burst; address wraps modulo 2^ADDR_W.
            if (w_last_beat && (r_remain != LEN_W'(1))) begin
              r_addr <= r_addr + ADDR_W'(r_bcnt);
              r_bcnt <= burst_of(r_remain - LEN_W'(1));
            end
          end
        end
        ST_DONE: begin
          r_done <= r_gnt;
        end
        default: begin
        end
      endcase
    end
  end

  assign ch_ack         = r_ack;
  assign ch_rvalid      = r_rvalid;
  assign ch_done        = r_done;
  assign ch_rdata       = r_rdata;
  assign busy           = (r_state != ST_IDLE);
  assign avm_read       = (r_state == ST_CMD);
  assign avm_address    = r_addr;
  assign avm_burstcount = r_bcnt;

endmodule

// File: doc/sdram_read_arbiter.md
SDRAM_READ_ARBITER -- requirements
Module: sdram_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of requesting channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 64, Avalon and channel data width.
REQ-003 SHALL have parameter ADDR_W, default 29, Avalon word-address width.
REQ-004 SHALL have parameter BURST_W, default 8; maximum burst is MAX_BURST = 2^(BURST_W-1) words (default 128).
REQ-005 SHALL have parameter LEN_W, default 16, channel transfer-length width in words.
REQ-006 SHALL have port clk  in  1  sole clock; all logic is rising-edge.
REQ-007 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port ch_req  in  NUM_CH  per-channel transfer request, level, held until ch_ack.
REQ-009 SHALL have port ch_addr  in  NUM_CH*ADDR_W  per-channel start word address, stable while ch_req is high.
REQ-010 SHALL have port ch_len  in  NUM_CH*LEN_W  per-channel length in words, stable while ch_req is high.
REQ-011 SHALL have port ch_ack  out  NUM_CH  one-cycle pulse: request accepted.
REQ-012 SHALL have port ch_rdata  out  DATA_W  read data, shared by all channels.
REQ-013 SHALL have port ch_rvalid  out  NUM_CH  one-hot beat qualifier for ch_rdata; no backpressure.
REQ-014 SHALL have port ch_done  out  NUM_CH  one-cycle pulse: transfer complete.
REQ-015 SHALL have port busy  out  1  high whenever the FSM is not IDLE.
REQ-016 SHALL have ports avm_address  out  ADDR_W, avm_burstcount  out  BURST_W, avm_read  out  1, avm_waitrequest  in  1, avm_readdata  in  DATA_W, avm_readdatavalid  in  1 (Avalon-MM burst read master toward the f2h SDRAM port).

Function
REQ-017 SHALL implement FSM states IDLE, CMD, DATA, DONE.
REQ-018 IDLE: when any ch_req is high, SHALL grant by round-robin starting at (last granted + 1) mod NUM_CH, pulse ch_ack of the winner, latch its addr/len, go to CMD next cycle; initial priority after reset is channel 0.
REQ-019 A request with ch_len = 0 SHALL be acked, produce ch_done on the following cycle via DONE, and issue no Avalon command.
REQ-020 CMD: SHALL drive avm_read = 1, avm_address = current address, avm_burstcount = min(remaining, MAX_BURST), held constant until a cycle with avm_waitrequest = 0, then go to DATA.
REQ-021 DATA: each cycle with avm_readdatavalid = 1 SHALL register avm_readdata to ch_rdata and assert ch_rvalid of the granted channel one cycle later (latency exactly 1).
REQ-022 After the last beat of a burst, if words remain, SHALL advance address by the burst length (modulo 2^ADDR_W, wrap permitted) and return to CMD; otherwise go to DONE.
REQ-023 DONE: SHALL pulse ch_done of the granted channel for one cycle, in the cycle after its final ch_rvalid, then return to IDLE.
REQ-024 Exactly one burst SHALL be outstanding at any time; avm_read SHALL be 0 outside CMD.
REQ-025 readdatavalid beats received outside DATA SHALL be ignored.
REQ-026 ch_req changes on non-granted channels during a transfer SHALL not affect it.

Reset
REQ-027 On reset_n low, asynchronously: state IDLE, rr pointer to channel 0, avm_read 0, avm_address 0, avm_burstcount 0, ch_ack/ch_rvalid/ch_done 0, ch_rdata 0, busy 0.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no ch_done; the interconnect is reset by the same reset_n.

Structure
REQ-029 State encoding typedef, MAX_BURST derivation and default parameter constants SHALL live in shared package sdram_read_pkg.
REQ-030 Round-robin grant logic SHALL be the sub-module rr_arbiter (NUM_CH-wide request in, one-hot grant out, advance input).

Verification
REQ-031 Single request ch1 len=4 addr=0x100, waitrequest low -> one command addr 0x100 burstcount 4, four ch_rvalid[1] beats with data in order, ch_done[1] one cycle after last beat.
REQ-032 ch0 len=300 -> bursts 128@A, 128@A+128, 44@A+256; 300 beats on ch_rvalid[0], single ch_done.
REQ-033 All three channels request simultaneously, len=2 each -> grants 0,1,2 in order; re-request all -> 0,1,2 again.
REQ-034 waitrequest held high 5 cycles in CMD -> address/burstcount/read stable for those cycles; beat count unaffected.
REQ-035 ch2 len=0 -> ch_ack[2], ch_done[2] next cycle, avm_read never asserted.
REQ-036 reset_n low during DATA of len=8 after 3 beats -> all outputs 0 immediately, no ch_done, new request after reset served from channel 0 priority.
